xif_commit_buffer: RTL and testbench

- Per-instruction commit/kill tracker and result reorder buffer between a CORE-V-XIF coprocessor datapath and the XIF result interface.
- Holds up to DEPTH outstanding accepted instructions.
- Releases each result only after its commit, strictly in issue order.
- Silently discards results of killed instructions by XIF ID; no global flush of the datapath is needed.

---
 rtl/xif_commit_buffer.sv | 181 ++++++++++++++++++
 tb/tb_xif_commit_buffer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_commit_buffer.sv
// Commit/kill tracker and in-order result buffer between a XIF coprocessor datapath and the
// XIF result interface. Results leave only after commit, strictly in issue order; killed
// instructions are retired silently once their datapath result has come back.
module xif_commit_buffer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned XIF_ID_WIDTH = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // Issue side
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  input  logic [XIF_ID_WIDTH-1:0] alloc_id_i,
  // Commit side
  input  logic                    commit_valid_i,
  input  logic [XIF_ID_WIDTH-1:0] commit_id_i,
  input  logic                    commit_kill_i,
  // Datapath result side
  input  logic                    cp_valid_i,
  output logic                    cp_ready_o,
  input  logic [XIF_ID_WIDTH-1:0] cp_id_i,
  input  logic [4:0]              cp_rd_i,
  input  logic [DATA_WIDTH-1:0]   cp_data_i,
  // XIF result side
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic [XIF_ID_WIDTH-1:0] result_id_o,
  output logic [4:0]              result_rd_o,
  output logic [DATA_WIDTH-1:0]   result_data_o,
  // Status
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [XIF_ID_WIDTH-1:0] id_q   [DEPTH];
  logic [XIF_ID_WIDTH-1:0] id_d   [DEPTH];
  logic [4:0]              rd_q   [DEPTH];
  logic [4:0]              rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_d [DEPTH];

  logic [DEPTH-1:0] live_q, live_d;
  logic [DEPTH-1:0] committed_q, committed_d;
  logic [DEPTH-1:0] killed_q, killed_d;
  logic [DEPTH-1:0] done_q, done_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic            err_q, err_d;

  logic [IdxW-1:0] head_idx, tail_idx;
  logic            full, alloc_fire;
  logic            head_emit, head_drop, retire;
  logic            cp_hit;
  logic            alloc_id_live;

  assign head_idx   = head_q[IdxW-1:0];
  assign tail_idx   = tail_q[IdxW-1:0];
  assign full       = (head_idx == tail_idx) && (head_q[IdxW] != tail_q[IdxW]);
  assign alloc_fire = alloc_valid_i && !full;

  assign head_emit = live_q[head_idx] && done_q[head_idx] && committed_q[head_idx] &&
                     !killed_q[head_idx];
  assign head_drop = live_q[head_idx] && done_q[head_idx] && killed_q[head_idx];
  assign retire    = head_drop || (head_emit && result_ready_i);

  // Next state: allocate, then apply commit (new slot included), datapath result
  // (registered live slots only), and finally head retirement.
  always_comb begin
    id_d        = id_q;
    rd_d        = rd_q;
    data_d      = data_q;
    live_d      = live_q;
    committed_d = committed_q;
    killed_d    = killed_q;
    done_d      = done_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cp_hit      = 1'b0;

    if (alloc_fire) begin
      id_d[tail_idx]        = alloc_id_i;
      live_d[tail_idx]      = 1'b1;
      committed_d[tail_idx] = 1'b0;
      killed_d[tail_idx]    = 1'b0;
      done_d[tail_idx]      = 1'b0;
      tail_d                = tail_q + PtrW'(1);
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      // A slot already resolved ignores further commits.
      if (commit_valid_i && live_d[i] && (id_d[i] == commit_id_i) &&
          !committed_d[i] && !killed_d[i]) begin
        if (commit_kill_i) begin
          killed_d[i] = 1'b1;
        end else begin
          committed_d[i] = 1'b1;
        end
      end
      if (cp_valid_i && live_q[i] && (id_q[i] == cp_id_i) && !done_q[i]) begin
        rd_d[i]   = cp_rd_i;
        data_d[i] = cp_data_i;
        done_d[i] = 1'b1;
        cp_hit    = 1'b1;
      end
    end

    if (retire) begin
      live_d[head_idx] = 1'b0;
      head_d           = head_q + PtrW'(1);
    end

    err_d = err_q || (cp_valid_i && !cp_hit);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      id_q        <= '{default: '0};
      rd_q        <= '{default: '0};
      data_q      <= '{default: '0};
      live_q      <= '0;
      committed_q <= '0;
      killed_q    <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      id_q        <= id_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      live_q      <= live_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
      done_q      <= done_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      err_q       <= err_d;
    end
  end

  // Outputs come from registered state only; payload is zero when nothing is offered.
  always_comb begin
    alloc_ready_o  = !full;
    cp_ready_o     = 1'b1;
    count_o        = tail_q - head_q;
    err_o          = err_q;
    result_valid_o = head_emit;
    result_id_o    = '0;
    result_rd_o    = '0;
    result_data_o  = '0;
    if (head_emit) begin
      result_id_o   = id_q[head_idx];
      result_rd_o   = rd_q[head_idx];
      result_data_o = data_q[head_idx];
    end
  end

  // Does the incoming alloc ID collide with a slot that is still live?
  always_comb begin
    alloc_id_live = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (id_q[i] == alloc_id_i)) begin
        alloc_id_live = 1'b1;
      end
    end
  end

  a_no_alloc_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    alloc_valid_i |-> alloc_ready_o);

  a_unique_live_id : assert property (@(posedge clk_i) disable iff (!rst_ni)
    alloc_fire |-> !alloc_id_live);

endmodule

// File: tb/tb_xif_commit_buffer.sv
// Scoreboard bench for xif_commit_buffer: directed scenarios plus a randomized phase checked
// against an in-order list model of outstanding instructions.
module tb_xif_commit_buffer;
  localparam int DW    = 32;
  localparam int IW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alloc_valid, alloc_ready;
  logic [IW-1:0] alloc_id;
  logic          commit_valid, commit_kill;
  logic [IW-1:0] commit_id;
  logic          cp_valid, cp_ready;
  logic [IW-1:0] cp_id;
  logic [4:0]    cp_rd;
  logic [DW-1:0] cp_data;
  logic          result_valid, result_ready;
  logic [IW-1:0] result_id;
  logic [4:0]    result_rd;
  logic [DW-1:0] result_data;
  logic [2:0]    count;
  logic          err;

  xif_commit_buffer #(.DATA_WIDTH(DW), .XIF_ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_id_i(alloc_id),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .cp_valid_i(cp_valid), .cp_ready_o(cp_ready), .cp_id_i(cp_id), .cp_rd_i(cp_rd),
    .cp_data_i(cp_data),
    .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
    .result_rd_o(result_rd), .result_data_o(result_data),
    .count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } res_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          silent;
  } pr_t;

  typedef struct {
    logic [IW-1:0] id;
    bit            com;
    bit            kil;
    bit            done;
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  res_t exp_q[$];   // results the DUT must emit, in order
  pr_t  pr_q[$];    // resolved instructions awaiting DUT retirement (ID reuse guard)
  ent_t mq[$];      // outstanding instructions, oldest first
  int   free_at[16];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on handshake, payload stability while stalled.
  logic prev_stall = 1'b0;
  res_t prev_res;
  res_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(result_valid), 64'd1);
        chk("stall_payload", 64'({result_id, result_rd, result_data}), 64'(prev_res));
      end
      if (result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d, expected no result", result_id);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", 64'({result_id, result_rd, result_data}), 64'(mon_e));
        end
        while (pr_q.size() > 0 && pr_q[0].silent) begin
          free_at[pr_q[0].id] = cyc + 3;
          void'(pr_q.pop_front());
        end
        if (pr_q.size() > 0) begin
          free_at[pr_q[0].id] = cyc + 3;
          void'(pr_q.pop_front());
        end
        while (pr_q.size() > 0 && pr_q[0].silent) begin
          free_at[pr_q[0].id] = cyc + DEPTH + 4;
          void'(pr_q.pop_front());
        end
      end
      prev_stall = result_valid && !result_ready;
      prev_res   = {result_id, result_rd, result_data};
    end
  end

  task automatic drive_idle();
    alloc_valid  = 1'b0;
    alloc_id     = '0;
    commit_valid = 1'b0;
    commit_id    = '0;
    commit_kill  = 1'b0;
    cp_valid     = 1'b0;
    cp_id        = '0;
    cp_rd        = '0;
    cp_data      = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_mq(input int id);
    foreach (mq[i]) if (int'(mq[i].id) == id) return 1'b1;
    return 1'b0;
  endfunction

  // One randomized cycle; fresh=0 drains (no allocs, resolve everything, always ready).
  task automatic rand_cycle(input bit fresh);
    int   cand[$];
    int   k;
    ent_t e;
    drive_idle();
    result_ready = fresh ? ($urandom_range(3) != 0) : 1'b1;

    cand = {};
    foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(1) == 1) begin
      k          = cand[$urandom_range(cand.size() - 1)];
      cp_valid   = 1'b1;
      cp_id      = mq[k].id;
      cp_rd      = 5'($urandom_range(31));
      cp_data    = $urandom;
      mq[k].done = 1'b1;
      mq[k].rd   = cp_rd;
      mq[k].data = cp_data;
    end

    if (fresh && alloc_ready && $urandom_range(1) == 1) begin
      cand = {};
      for (int id = 0; id < 16; id++) if (free_at[id] <= cyc && !in_mq(id)) cand.push_back(id);
      if (cand.size() > 0) begin
        k           = cand[$urandom_range(cand.size() - 1)];
        alloc_valid = 1'b1;
        alloc_id    = IW'(k);
        e.id = IW'(k); e.com = 0; e.kil = 0; e.done = 0; e.rd = '0; e.data = '0;
        mq.push_back(e);
        free_at[k] = 1 << 30;
      end
    end

    cand = {};
    foreach (mq[i]) if (!mq[i].com && !mq[i].kil) cand.push_back(i);
    if (cand.size() > 0 && (!fresh || $urandom_range(1) == 1)) begin
      k            = cand[$urandom_range(cand.size() - 1)];
      commit_valid = 1'b1;
      commit_id    = mq[k].id;
      commit_kill  = ($urandom_range(3) == 0);
      if (commit_kill) mq[k].kil = 1'b1;
      else mq[k].com = 1'b1;
    end else if (fresh && $urandom_range(7) == 0) begin
      // Commit for an ID that is not outstanding: must have no effect.
      cand = {};
      for (int id = 0; id < 16; id++) if (!in_mq(id)) cand.push_back(id);
      if (cand.size() > 0) begin
        commit_valid = 1'b1;
        commit_id    = IW'(cand[$urandom_range(cand.size() - 1)]);
        commit_kill  = 1'($urandom_range(1));
      end
    end

    while (mq.size() > 0 && mq[0].done && (mq[0].com || mq[0].kil)) begin
      if (mq[0].com) begin
        exp_q.push_back({mq[0].id, mq[0].rd, mq[0].data});
        pr_q.push_back({mq[0].id, 1'b0});
      end else begin
        pr_q.push_back({mq[0].id, 1'b1});
      end
      void'(mq.pop_front());
    end
    while (pr_q.size() > 0 && pr_q[0].silent) begin
      free_at[pr_q[0].id] = cyc + DEPTH + 4;
      void'(pr_q.pop_front());
    end
    step();
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n        = 1'b0;
    result_ready = 1'b1;
    drive_idle();
    step();
    step();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(result_valid), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_payload", 64'({result_id, result_rd, result_data}), 64'd0);
    rst_n = 1'b1;
    step();
    chk("reset_alloc_ready", 64'(alloc_ready), 64'd1);

    // Single op
    alloc_valid = 1; alloc_id = 3; step(); drive_idle();
    commit_valid = 1; commit_id = 3; step(); drive_idle();
    cp_valid = 1; cp_id = 3; cp_rd = 7; cp_data = 32'hDEADBEEF;
    exp_q.push_back({4'd3, 5'd7, 32'hDEADBEEF});
    step(); drive_idle();
    chk("single_valid", 64'(result_valid), 64'd1);
    chk("single_count", 64'(count), 64'd1);
    step();
    chk("single_count_after", 64'(count), 64'd0);
    chk("single_valid_after", 64'(result_valid), 64'd0);

    // Kill: id 1 killed, id 2 committed, results return 2 then 1
    alloc_valid = 1; alloc_id = 1; step(); drive_idle();
    alloc_valid = 1; alloc_id = 2; step(); drive_idle();
    commit_valid = 1; commit_id = 1; commit_kill = 1; step(); drive_idle();
    commit_valid = 1; commit_id = 2; step(); drive_idle();
    cp_valid = 1; cp_id = 2; cp_rd = 2; cp_data = 32'h2222_0002;
    exp_q.push_back({4'd2, 5'd2, 32'h2222_0002});
    step(); drive_idle();
    chk("kill_head_blocks", 64'(result_valid), 64'd0);
    cp_valid = 1; cp_id = 1; cp_rd = 1; cp_data = 32'h1111_0001;
    step(); drive_idle();
    chk("kill_silent", 64'(result_valid), 64'd0);
    step();
    chk("kill_younger_valid", 64'(result_valid), 64'd1);
    chk("kill_younger_id", 64'(result_id), 64'd2);
    step();
    chk("kill_count", 64'(count), 64'd0);

    // Fill and backpressure
    result_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      alloc_valid = 1; alloc_id = IW'(10 + k); commit_valid = 1; commit_id = IW'(10 + k);
      step(); drive_idle();
    end
    chk("fill_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("fill_count", 64'(count), 64'(DEPTH));
    for (int k = 0; k < DEPTH; k++) begin
      d = $urandom;
      cp_valid = 1; cp_id = IW'(10 + k); cp_rd = 5'(k + 1); cp_data = d;
      exp_q.push_back({IW'(10 + k), 5'(k + 1), d});
      step(); drive_idle();
    end
    for (int k = 0; k < 5; k++) step();
    chk("bp_valid", 64'(result_valid), 64'd1);
    chk("bp_id", 64'(result_id), 64'd10);
    result_ready = 1'b1;
    step();
    chk("bp_first_retire_count", 64'(count), 64'(DEPTH - 1));
    chk("bp_alloc_ready", 64'(alloc_ready), 64'd1);
    for (int k = 0; k < DEPTH - 1; k++) step();
    chk("bp_drained", 64'(count), 64'd0);
    chk("bp_exp_empty", 64'(exp_q.size()), 64'd0);

    // Same-cycle alloc + commit
    alloc_valid = 1; alloc_id = 5; commit_valid = 1; commit_id = 5; step(); drive_idle();
    cp_valid = 1; cp_id = 5; cp_rd = 5'd21; cp_data = 32'h0000_5555;
    exp_q.push_back({4'd5, 5'd21, 32'h0000_5555});
    step(); drive_idle();
    chk("same_cycle_valid", 64'(result_valid), 64'd1);
    step();
    chk("same_cycle_count", 64'(count), 64'd0);

    // Randomized phase
    for (int i = 0; i < 16; i++) free_at[i] = 0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 400 && mq.size() > 0; c++) rand_cycle(1'b0);
    chk("rand_model_drained", 64'(mq.size()), 64'd0);
    drive_idle();
    result_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
    chk("rand_exp_empty", 64'(exp_q.size()), 64'd0);
    for (int c = 0; c < DEPTH + 2; c++) step();
    chk("rand_count", 64'(count), 64'd0);
    chk("rand_err", 64'(err), 64'd0);

    // Stray datapath result
    cp_valid = 1; cp_id = 9; cp_rd = 3; cp_data = 32'hBAD0_0009; step(); drive_idle();
    chk("stray_err", 64'(err), 64'd1);
    chk("stray_count", 64'(count), 64'd0);
    alloc_valid = 1; alloc_id = 6; commit_valid = 1; commit_id = 6; step(); drive_idle();
    cp_valid = 1; cp_id = 6; cp_rd = 6; cp_data = 32'h6666_6666;
    exp_q.push_back({4'd6, 5'd6, 32'h6666_6666});
    step(); drive_idle();
    chk("stray_other_valid", 64'(result_valid), 64'd1);
    step();
    chk("stray_err_sticky", 64'(err), 64'd1);
    chk("stray_other_count", 64'(count), 64'd0);

    // Reset mid-operation with three live slots
    alloc_valid = 1; alloc_id = 1; step(); drive_idle();
    alloc_valid = 1; alloc_id = 2; commit_valid = 1; commit_id = 2; step(); drive_idle();
    alloc_valid = 1; alloc_id = 3; commit_valid = 1; commit_id = 3; step(); drive_idle();
    cp_valid = 1; cp_id = 2; step(); drive_idle();
    chk("midrst_count_before", 64'(count), 64'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_valid", 64'(result_valid), 64'd0);
    chk("midrst_err_cleared", 64'(err), 64'd0);
    chk("midrst_alloc_ready", 64'(alloc_ready), 64'd1);
    cp_valid = 1; cp_id = 3; step(); drive_idle();
    cp_valid = 1; cp_id = 1; step(); drive_idle();
    chk("midrst_late_err", 64'(err), 64'd1);
    chk("midrst_late_valid", 64'(result_valid), 64'd0);
    for (int c = 0; c < 4; c++) step();
    chk("midrst_late_count", 64'(count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
